nnet_result_framer: RTL and testbench

NNET_RESULT_FRAMER -- requirements
Module: nnet_result_framer

---
 rtl/nnet_result_framer_pkg.sv | 30 +++
 rtl/nnet_axis_out_reg.sv | 37 +++
 rtl/nnet_result_framer.sv | 140 ++++++++++++++
 tb/tb_nnet_result_framer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnet_result_framer_pkg.sv
// Shared constants, state encoding and beat payload for the neural-net result framer.
package nnet_result_framer_pkg;

  localparam int unsigned SR_USER_SPP_DEF = 131;
  localparam int unsigned SPP_RESET_DEF   = 64;
  localparam int unsigned IN_W            = 16;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned USER_W          = 128;
  localparam int unsigned LEN_W           = 16;
  localparam int unsigned CNT_W           = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // vec_end travels with the beat so the vector counter bumps on output transfer
  typedef struct packed {
    logic [USER_W-1:0] tuser;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              vec_end;
  } beat_t;

  // Zero-length settings degrade to single-sample packets/vectors
  function automatic logic [LEN_W-1:0] nz_len(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

endpackage

// File: rtl/nnet_axis_out_reg.sv
// One-stage AXI-stream output register; clear drops a held beat.
module nnet_axis_out_reg
  import nnet_result_framer_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_clr,
  input  logic  i_valid,
  input  beat_t i_beat,
  output logic  o_ready_c,
  output logic  o_valid,
  output beat_t o_beat,
  input  logic  i_ready
);

  logic  r_valid;
  beat_t r_beat;

  assign o_ready_c = ~r_valid | i_ready;
  assign o_valid   = r_valid;
  assign o_beat    = r_beat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_valid && o_ready_c) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nnet_result_framer.sv
// Frames the tlast-less neural-net result stream into SPP-limited packets that never span vectors.
module nnet_result_framer
  import nnet_result_framer_pkg::*;
#(
  parameter int unsigned SR_USER_SPP = SR_USER_SPP_DEF,
  parameter int unsigned SPP_RESET   = SPP_RESET_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [LEN_W-1:0]  nnet_size_out,
  input  logic              hdr_stb,
  input  logic [USER_W-1:0] hdr_tuser,
  input  logic [IN_W-1:0]   i_tdata,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [USER_W-1:0] o_tuser,
  output logic [LEN_W-1:0]  spp_out,
  output logic [CNT_W-1:0]  vec_count
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_spp;
  logic [LEN_W-1:0]  r_pkt_len;
  logic [LEN_W-1:0]  r_vec_len;
  logic [LEN_W-1:0]  r_pkt_idx;
  logic [LEN_W-1:0]  r_vec_idx;
  logic [USER_W-1:0] r_hdr;
  logic [USER_W-1:0] r_pkt_user;
  logic [CNT_W-1:0]  r_vec_count;

  logic              w_out_ready;
  logic              w_acc;
  logic              w_pkt_start;
  logic              w_vec_start;
  logic [LEN_W-1:0]  w_pkt_len;
  logic [LEN_W-1:0]  w_vec_len;
  logic              w_pkt_last;
  logic              w_vec_last;
  logic              w_last;
  beat_t             w_beat;
  beat_t             w_out_beat;
  logic              w_out_valid;
  logic              w_unused_ok;

  assign w_unused_ok = ^set_data[31:LEN_W];

  // clear wins over an incoming sample
  assign i_tready = w_out_ready & ~clear;
  assign w_acc    = i_tvalid & i_tready;

  // Lengths are sampled only at packet/vector start so mid-flight changes wait
  assign w_pkt_start = (r_state == IDLE);
  assign w_vec_start = (r_vec_idx == '0);
  assign w_pkt_len   = w_pkt_start ? nz_len(r_spp) : r_pkt_len;
  assign w_vec_len   = w_vec_start ? nz_len(nnet_size_out) : r_vec_len;
  assign w_pkt_last  = (r_pkt_idx == w_pkt_len - LEN_W'(1));
  assign w_vec_last  = (r_vec_idx == w_vec_len - LEN_W'(1));
  assign w_last      = w_pkt_last | w_vec_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_beat         = '0;
    w_beat.tdata   = {16'd0, i_tdata};
    w_beat.tlast   = w_last;
    w_beat.vec_end = w_vec_last;
    w_beat.tuser   = w_pkt_start ? r_hdr : r_pkt_user;
    case (r_state)
      IDLE:   if (w_acc && !w_last) w_state_nxt = IN_PKT;
      IN_PKT: if (w_acc && w_last)  w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spp       <= LEN_W'(SPP_RESET);
      r_hdr       <= '0;
      r_pkt_user  <= '0;
      r_pkt_len   <= '0;
      r_vec_len   <= '0;
      r_pkt_idx   <= '0;
      r_vec_idx   <= '0;
      r_vec_count <= '0;
    end else begin
      if (set_stb && (set_addr == 8'(SR_USER_SPP))) r_spp <= set_data[LEN_W-1:0];
      if (hdr_stb) r_hdr <= hdr_tuser;
      if (clear) begin
        r_pkt_idx   <= '0;
        r_vec_idx   <= '0;
        r_vec_count <= '0;
      end else begin
        if (w_acc) begin
          if (w_pkt_start) begin
            r_pkt_len  <= w_pkt_len;
            r_pkt_user <= r_hdr;
          end
          if (w_vec_start) r_vec_len <= w_vec_len;
          r_pkt_idx <= w_last     ? '0 : r_pkt_idx + LEN_W'(1);
          r_vec_idx <= w_vec_last ? '0 : r_vec_idx + LEN_W'(1);
        end
        if (w_out_valid && o_tready && w_out_beat.vec_end)
          r_vec_count <= r_vec_count + CNT_W'(1);
      end
    end
  end

  nnet_axis_out_reg u_out_reg (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_clr     (clear),
    .i_valid   (w_acc),
    .i_beat    (w_beat),
    .o_ready_c (w_out_ready),
    .o_valid   (w_out_valid),
    .o_beat    (w_out_beat),
    .i_ready   (o_tready)
  );

  assign o_tvalid  = w_out_valid;
  assign o_tdata   = w_out_beat.tdata;
  assign o_tlast   = w_out_beat.tlast;
  assign o_tuser   = w_out_beat.tuser;
  assign spp_out   = r_spp;
  assign vec_count = r_vec_count;

endmodule

// File: tb/tb_nnet_result_framer.sv
// Randomised bench for nnet_result_framer against a packet-splitting reference model.
module tb_nnet_result_framer;

  localparam logic [7:0] SR_ADDR = 8'd131;

  logic         clk = 1'b0;
  logic         reset, clear, set_stb, hdr_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic [15:0]  nnet_size_out;
  logic [127:0] hdr_tuser;
  logic [15:0]  i_tdata;
  logic         i_tvalid, i_tready;
  logic [31:0]  o_tdata;
  logic         o_tlast, o_tvalid, o_tready;
  logic [127:0] o_tuser;
  logic [15:0]  spp_out;
  logic [31:0]  vec_count;

  nnet_result_framer dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .nnet_size_out(nnet_size_out), .hdr_stb(hdr_stb), .hdr_tuser(hdr_tuser),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tuser(o_tuser), .spp_out(spp_out), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  data;
    logic         last;
    logic [127:0] user;
  } exp_t;

  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         exp_q[$];
  logic [15:0]  stim_q[$];
  int           exp_vec;
  int           rdy_mode;   // 0: always ready, 1: random 50%, 2: stalled
  logic [127:0] cur_hdr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1) o_tready = 1'($urandom_range(1, 0));
    else               o_tready = (rdy_mode == 0);
  end

  // Output monitor: in-order comparison plus hold stability under backpressure
  logic         hold_prev = 1'b0;
  logic [31:0]  hold_data;
  logic         hold_last;
  logic [127:0] hold_user;
  exp_t         mon_e;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", o_tvalid, 1);
        check("hold_data", o_tdata, hold_data);
        check("hold_last", o_tlast, hold_last);
        check("hold_user", o_tuser, hold_user);
      end
      if (o_tvalid && o_tready) begin
        check("beat_expected", 128'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("tdata", o_tdata, mon_e.data);
          check("tlast", o_tlast, mon_e.last);
          check("tuser", o_tuser, mon_e.user);
        end
      end
      hold_prev = o_tvalid && !o_tready && !clear;
      hold_data = o_tdata;
      hold_last = o_tlast;
      hold_user = o_tuser;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic hdr_pulse(input logic [127:0] v);
    hdr_stb = 1'b1; hdr_tuser = v;
    tick();
    hdr_stb = 1'b0;
    cur_hdr = v;
  endtask

  task automatic push(input logic [15:0] d, input logic l, input logic [127:0] u);
    exp_t e;
    e.data = {16'd0, d}; e.last = l; e.user = u;
    exp_q.push_back(e);
  endtask

  // Whole vectors split into chunks of min(SPP, remaining), zero treated as one
  task automatic model(input int spp, input int sz, input logic [127:0] user);
    int s, v, idx, rem, len;
    s = (spp == 0) ? 1 : spp;
    v = (sz == 0) ? 1 : sz;
    idx = 0;
    while (idx < stim_q.size()) begin
      rem = v;
      while (rem > 0 && idx < stim_q.size()) begin
        len = (rem < s) ? rem : s;
        for (int j = 0; j < len && idx < stim_q.size(); j++) begin
          push(stim_q[idx], j == len - 1, user);
          idx++;
        end
        rem -= len;
      end
      if (rem == 0) exp_vec++;
    end
  endtask

  task automatic send_stim(output int cycles);
    int guard;
    cycles = 0;
    foreach (stim_q[k]) begin
      guard = 0;
      i_tvalid = 1'b1;
      i_tdata  = stim_q[k];
      @(negedge clk);
      while (!i_tready && guard < 2000) begin
        guard++; cycles++;
        @(negedge clk);
      end
      check("input_accept", i_tready, 1);
      @(posedge clk);
      #1;
      cycles++;
    end
    i_tvalid = 1'b0;
    stim_q.delete();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      tick(); g++;
    end
    check("drain_empty", 128'(exp_q.size()), 0);
    tick(2);
  endtask

  int tbl_spp[6] = '{4, 16, 0, 4, 5, 1};
  int tbl_sz[6]  = '{10, 5, 3, 0, 13, 1};
  int tbl_nv[6]  = '{1, 2, 1, 3, 77, 2};
  int tbl_rm[6]  = '{0, 0, 0, 0, 1, 1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc, n;
    logic [127:0] h_old, h_new;
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    nnet_size_out = 16'd1; hdr_stb = 1'b0; hdr_tuser = '0; i_tdata = '0; i_tvalid = 1'b0;
    o_tready = 1'b1; rdy_mode = 0; cur_hdr = '0; exp_vec = 0;
    tick(3);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_tuser", o_tuser, 0);
    check("rst_spp", spp_out, 64);
    check("rst_vec_count", vec_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", i_tready, 1);
    tick();

    write_reg(8'd130, 32'd7);
    check("spp_other_addr", spp_out, 64);

    // Table-driven scenarios: fixed SPP/size, constant or random backpressure
    for (int t = 0; t < 6; t++) begin
      rdy_mode = tbl_rm[t];
      write_reg(SR_ADDR, 32'(tbl_spp[t]));
      if (tbl_spp[t] != 0) check("spp_out", spp_out, 128'(tbl_spp[t]));
      nnet_size_out = 16'(tbl_sz[t]);
      hdr_pulse({$urandom, $urandom, $urandom, $urandom});
      n = ((tbl_sz[t] == 0) ? 1 : tbl_sz[t]) * tbl_nv[t];
      for (int k = 0; k < n; k++)
        stim_q.push_back((tbl_rm[t] == 0) ? 16'(k + 1) : 16'($urandom));
      model(tbl_spp[t], tbl_sz[t], cur_hdr);
      send_stim(cyc);
      if (tbl_rm[t] == 0) check("throughput", 128'(cyc), 128'(n));
      drain();
      check("vec_count", vec_count, 128'(exp_vec));
    end

    // SPP rewritten mid-packet takes effect only at the next packet
    rdy_mode = 0;
    write_reg(SR_ADDR, 32'd8);
    nnet_size_out = 16'd11;
    for (int k = 0; k < 11; k++) push(16'(k + 1), (k == 7) || (k == 10), cur_hdr);
    exp_vec++;
    for (int k = 0; k < 3; k++) stim_q.push_back(16'(k + 1));
    send_stim(cyc);
    write_reg(SR_ADDR, 32'd3);
    for (int k = 3; k < 11; k++) stim_q.push_back(16'(k + 1));
    send_stim(cyc);
    drain();
    check("vec_count_spp_change", vec_count, 128'(exp_vec));

    // Header update mid-packet applies to the following packet only
    write_reg(SR_ADDR, 32'd4);
    nnet_size_out = 16'd8;
    h_old = cur_hdr;
    for (int k = 0; k < 8; k++) push(16'(k + 1), (k == 3) || (k == 7), (k < 4) ? h_old : 128'hA5);
    exp_vec++;
    stim_q.push_back(16'd1); stim_q.push_back(16'd2);
    send_stim(cyc);
    hdr_pulse(128'hA5);
    for (int k = 2; k < 8; k++) stim_q.push_back(16'(k + 1));
    send_stim(cyc);
    drain();

    // Header strobe coincident with packet start: packet keeps the old header
    write_reg(SR_ADDR, 32'd2);
    nnet_size_out = 16'd4;
    h_old = cur_hdr;
    h_new = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) push(16'(k + 1), (k == 1) || (k == 3), (k < 2) ? h_old : h_new);
    exp_vec++;
    for (int k = 0; k < 4; k++) stim_q.push_back(16'(k + 1));
    hdr_stb = 1'b1; hdr_tuser = h_new;
    send_stim(cyc);
    hdr_stb = 1'b0;
    cur_hdr = h_new;
    drain();
    check("vec_count_hdr", vec_count, 128'(exp_vec));

    // Clear after 3 of 4 beats, third beat still held in the output stage
    write_reg(SR_ADDR, 32'd4);
    nnet_size_out = 16'd10;
    push(16'd1, 1'b0, cur_hdr); push(16'd2, 1'b0, cur_hdr);
    stim_q.push_back(16'd1); stim_q.push_back(16'd2);
    send_stim(cyc);
    tick(2);
    rdy_mode = 2;
    tick();
    stim_q.push_back(16'd3);
    send_stim(cyc);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_tvalid", o_tvalid, 0);
    check("clear_vec_count", vec_count, 0);
    check("clear_spp", spp_out, 4);
    exp_vec = 0;
    rdy_mode = 0;
    tick();
    for (int k = 0; k < 10; k++) stim_q.push_back(16'(k + 100));
    model(4, 10, cur_hdr);
    send_stim(cyc);
    drain();
    check("vec_count_after_clear", vec_count, 128'(exp_vec));

    // Reset mid-packet discards the held beat
    rdy_mode = 2;
    tick();
    stim_q.push_back(16'h55);
    send_stim(cyc);
    check("held_before_reset", o_tvalid, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_tvalid", o_tvalid, 0);
    check("mid_rst_tlast", o_tlast, 0);
    check("mid_rst_spp", spp_out, 64);
    check("mid_rst_vec_count", vec_count, 0);
    reset = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("mid_rst_ready", i_tready, 1);
    tick(3);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
